down_interval_timer: RTL and testbench
======================================

# down_interval_timer

Programmable down-counting interval timer built from a ripple chain of 4-bit down-counter slices with borrow propagation; it is the count-down, terminal-borrow counterpart to the team's 4-bit up-counter with carry-out. It loads a period, counts to zero, and emits a one-cycle `tick`. It runs either one-shot or auto-reload, and sits between a control sequencer (start/stop) and any block needing periodic enables.

## Interface
- `NIBBLES`, default 2: number of 4-bit slices; counter width W = 4*NIBBLES.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level sampled each edge; loads `load_val` and runs.
- `stop`  in  1  aborts a run; has priority over `start`.
- `auto_reload`  in  1  1 = periodic, 0 = one-shot; sampled at terminal count.
- `load_val`  in  W  period value N; sampled on start and on each reload.
- `count`  out  W  current counter value, registered.
- `busy`  out  1  high while in RUN.
- `tick`  out  1  registered one-cycle pulse when `count` reaches 0 in RUN.
- `pause`  in  1  present only with `TIMER_PAUSE_EN`; see Configuration.

## Operation
- Reset values: `count`=0, `busy`=0, `tick`=0, state IDLE. Reset mid-run aborts immediately with no tick.
- States: IDLE, RUN.
- IDLE: `count` holds. `start`=1, `stop`=0, and `load_val`≠0: `count`<=`load_val`, go to RUN. `load_val`=0: start is ignored; stay in IDLE, no tick. `stop`=1: stay in IDLE.
- RUN, `count`>1: decrement by 1 per cycle. Borrow ripples slice to slice; slice k decrements only when slices 0..k-1 are all zero.
- RUN, `count`=1: next value 0, and `tick`=1 in that same cycle, coincident with `count`=0.
- RUN, `count`=0, one cycle only:
  - `auto_reload`=1 and `load_val`≠0: `count`<=`load_val`, stay in RUN.
  - Otherwise: go to IDLE; `count` stays 0.
- RUN, `stop`=1: go to IDLE next edge; `count` freezes at its current value; no tick. Takes precedence over terminal and reload.
- RUN, `start`=1 and `stop`=0: restart with `count`<=`load_val` (`load_val`=0 goes to IDLE); no tick. Restart on the terminal-0 cycle also suppresses nothing: the tick was already emitted.
- Width rule: decrement is modulo 2^W. Underflow is unreachable because 0 is never decremented.

## Timing
- Start sampled at edge E0: `count`=N and `busy`=1 after E0. `tick` and `count`=0 occur after edge E0+N.
- Auto-reload period is N+1 cycles, tick to tick.
- One-shot: `busy` falls one cycle after `tick`.
- All outputs come directly from flops; no combinational input-to-output paths.

## Configuration
- `TIMER_PAUSE_EN` defined: `pause` port exists. `pause`=1 in RUN freezes `count` and state, and no tick is generated. `stop` and `start` still act while paused, with the same priority. `pause` has no effect in IDLE.
- Undefined: no `pause` port, and the counter always decrements in RUN.

## Structure
- Shared package `timer_pkg`:
  - state typedef with IDLE and RUN;
  - constant `NIBBLE_W`=4.
- Sub-module `down_counter_4bit`, instantiated NIBBLES times in a generate loop:
  - inputs `clk`, `rst`, `load`, `dec_en`, `bin`, `par_in[3:0]`;
  - outputs `par_out[3:0]`, `bout`;
  - `bout` = `bin` & (`par_out`==0).
- Top level: FSM, tick flop, and borrow chain wiring. Slice 0 `bin` = run enable.

## Test plan
- Reset with `count` mid-run at 0x37 -> immediately `count`=0, `busy`=0, `tick`=0.
- NIBBLES=2, `load_val`=5, one-shot, `start` pulse -> `count` 5,4,3,2,1,0; `tick` in the 0 cycle; `busy` low next cycle.
- `load_val`=3, `auto_reload`=1 -> ticks every 4 cycles. Change `load_val` to 1 mid-run -> takes effect at next reload, period becomes 2.
- `load_val`=0x10 -> borrow crosses the nibble: 0x10 to 0x0F in one cycle, correct upper slice; `load_val`=0 with `start` -> stays IDLE, no tick.
- `stop` at `count`=2 -> IDLE with `count`=2, no tick. `start`+`stop` together in IDLE -> remains IDLE.
- With `TIMER_PAUSE_EN`, `load_val`=4, `pause` high 3 cycles at `count`=2 -> `count` holds at 2; tick arrives 3 cycles later than without pause.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the down-counting interval timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents:
//   state_t   - IDLE / RUN controller state
//   NIBBLE_W  - width of one counter slice
//   nib_zero  - helper that flags an all-zero slice value
package timer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // True when a slice value is zero. The borrow chain is built from this test.
    function automatic logic nib_zero(input logic [NIBBLE_W-1:0] v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/down_counter_4bit.sv
// One 4-bit slice of the ripple down-counter with borrow propagation.
// Latency: load or decrement is visible one cycle after the enabling edge.
// Backpressure: none; the slice acts every cycle its enables are high.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   load       - parallel load of par_in (wins over decrement)
//   dec_en     - global decrement permission from the controller
//   bin        - borrow in: all lower slices are zero (slice 0: run enable)
//   par_in     - parallel load value
//   par_out    - current slice value
//   bout       - borrow out: bin and this slice is zero
module down_counter_4bit
    import timer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                dec_en,
    input  logic                bin,
    input  logic [NIBBLE_W-1:0] par_in,
    output logic [NIBBLE_W-1:0] par_out,
    output logic                bout
);

    logic [NIBBLE_W-1:0] cnt_q;
    logic [NIBBLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = par_in;
        end else if (dec_en && bin) begin
            // A zero slice wraps to 0xF; that is exactly the borrow into
            // this slice being passed further up the chain.
            cnt_d = cnt_q - {{(NIBBLE_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign par_out = cnt_q;
    assign bout    = bin & nib_zero(cnt_q);

endmodule

// File: rtl/down_interval_timer.sv
// Programmable down-counting interval timer: load N, count to 0, pulse tick.
// Latency: count=N one cycle after start is sampled; tick N cycles later.
// Backpressure: none; stop aborts a run, optional pause freezes it.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   start        - load load_val and run (level sampled each edge)
//   stop         - abort run, priority over start
//   auto_reload  - 1 = periodic, 0 = one-shot (sampled at terminal count)
//   load_val     - period N; N = 0 is never started/reloaded
//   pause        - only with TIMER_PAUSE_EN: freeze a run in place
//   count        - registered counter value
//   busy         - registered, high while running
//   tick         - registered one-cycle pulse coincident with count reaching 0
// Optional feature macro: TIMER_PAUSE_EN adds the pause input.
module down_interval_timer
    import timer_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         auto_reload,
    input  logic [NIBBLE_W*NIBBLES-1:0]  load_val,
`ifdef TIMER_PAUSE_EN
    input  logic                         pause,
`endif
    output logic [NIBBLE_W*NIBBLES-1:0]  count,
    output logic                         busy,
    output logic                         tick
);

    localparam int W = NIBBLE_W * NIBBLES;

    state_t state_q;
    logic   busy_q;
    logic   tick_q;

    logic   pause_w;
    logic   lv_nz_w;
    logic   cnt_zero_w;
    logic   cnt_one_w;
    logic   load_w;
    logic   dec_ok_w;

    // borrow_w[k] is the borrow into slice k; borrow_w[NIBBLES] is high only
    // when running with every slice at zero, i.e. the terminal count.
    logic [NIBBLES:0] borrow_w;

`ifdef TIMER_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    assign lv_nz_w     = |load_val;
    assign borrow_w[0] = busy_q;
    assign cnt_zero_w  = borrow_w[NIBBLES];
    assign cnt_one_w   = (count == {{(W-1){1'b0}}, 1'b1});

    // Slice control. Priority inside RUN: stop, start, pause, terminal, count.
    always_comb begin
        load_w   = 1'b0;
        dec_ok_w = 1'b0;
        if (state_q == IDLE) begin
            load_w = start && !stop && lv_nz_w;
        end else if (!stop) begin
            if (start) begin
                load_w = lv_nz_w;
            end else if (!pause_w) begin
                if (cnt_zero_w) begin
                    load_w = auto_reload && lv_nz_w;
                end else begin
                    dec_ok_w = 1'b1;
                end
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NIBBLES; k++) begin : g_slice
            down_counter_4bit u_slice (
                .clk     (clk),
                .rst     (rst),
                .load    (load_w),
                .dec_en  (dec_ok_w),
                .bin     (borrow_w[k]),
                .par_in  (load_val[k*NIBBLE_W +: NIBBLE_W]),
                .par_out (count[k*NIBBLE_W +: NIBBLE_W]),
                .bout    (borrow_w[k+1])
            );
        end
    endgenerate

    // Controller FSM with registered busy/tick. The slices mirror the same
    // decision through load_w/dec_ok_w so count and tick move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop && lv_nz_w) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (start) begin
                        // Restart; a zero period cannot run, so drop to idle.
                        if (!lv_nz_w) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (pause_w) begin
                        state_q <= RUN;
                    end else if (cnt_zero_w) begin
                        // The terminal-0 cycle lasts one cycle: reload or retire.
                        if (!(auto_reload && lv_nz_w)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        // Stepping 1 -> 0: tick lands with count == 0.
                        tick_q <= cnt_one_w;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_down_interval_timer.sv
// Directed self-checking bench for down_interval_timer (NIBBLES = 2).
// Inputs change #1 after a rising edge; outputs are checked at that point.
module tb_down_interval_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [7:0] load_val;
`ifdef TIMER_PAUSE_EN
    logic       pause;
`endif
    logic [7:0] count;
    logic       busy;
    logic       tick;

    int total = 0;
    int bad   = 0;

    down_interval_timer #(.NIBBLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .load_val    (load_val),
`ifdef TIMER_PAUSE_EN
        .pause       (pause),
`endif
        .count       (count),
        .busy        (busy),
        .tick        (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] c, input logic b, input logic t);
        check({tag, "_count"}, {24'd0, count}, {24'd0, c});
        check({tag, "_busy"},  {31'd0, busy},  {31'd0, b});
        check({tag, "_tick"},  {31'd0, tick},  {31'd0, t});
    endtask

    int ar_cnt [12] = '{3, 2, 1, 0, 3, 2, 1, 0, 1, 0, 1, 0};
    bit ar_tck [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; auto_reload = 1'b0; load_val = 8'h00;
`ifdef TIMER_PAUSE_EN
        pause = 1'b0;
`endif
        step();
        step();
        check_out("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Asynchronous reset while running at 0x37.
        load_val = 8'h38; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_out("prerst", 8'h37, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_out("midrst", 8'h00, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // One-shot, N = 5: 5,4,3,2,1,0 with tick on 0, busy drops after.
        load_val = 8'h05; auto_reload = 1'b0; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) start = 1'b0;
            check_out($sformatf("os%0d", i), 8'(5 - i), 1'b1, (i == 5));
        end
        step();
        check_out("os_end", 8'h00, 1'b0, 1'b0);

        // Auto-reload N = 3 (period 4), then load_val -> 1 mid-run (period 2).
        load_val = 8'h03; auto_reload = 1'b1; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0)  start = 1'b0;
            check_out($sformatf("ar%0d", i), 8'(ar_cnt[i]), 1'b1, ar_tck[i]);
            if (i == 5)  load_val = 8'h01;
            if (i == 10) auto_reload = 1'b0;
        end
        step();
        check_out("ar_end", 8'h00, 1'b0, 1'b0);

        // Borrow across the nibble boundary, then stop.
        load_val = 8'h10; start = 1'b1;
        step();
        start = 1'b0;
        check_out("nib0", 8'h10, 1'b1, 1'b0);
        step();
        check_out("nib1", 8'h0F, 1'b1, 1'b0);
        step();
        check_out("nib2", 8'h0E, 1'b1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_out("nib_stop", 8'h0E, 1'b0, 1'b0);

        // Zero period start is ignored.
        load_val = 8'h00; start = 1'b1;
        step();
        check_out("zero0", 8'h0E, 1'b0, 1'b0);
        step();
        check_out("zero1", 8'h0E, 1'b0, 1'b0);

        // start + stop together in IDLE stays idle.
        load_val = 8'h07; start = 1'b1; stop = 1'b1;
        step();
        check_out("ststop", 8'h0E, 1'b0, 1'b0);
        start = 1'b0; stop = 1'b0;

        // Stop at count = 2: freeze at 2, no tick.
        load_val = 8'h04; start = 1'b1;
        step();
        start = 1'b0;
        check_out("stp0", 8'h04, 1'b1, 1'b0);
        step();
        step();
        check_out("stp2", 8'h02, 1'b1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_out("stp_idle", 8'h02, 1'b0, 1'b0);
        step();
        check_out("stp_hold", 8'h02, 1'b0, 1'b0);

        // Restart while running reloads the new period without a tick.
        load_val = 8'h09; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_out("rs1", 8'h08, 1'b1, 1'b0);
        load_val = 8'h06; start = 1'b1;
        step();
        start = 1'b0;
        check_out("rs_load", 8'h06, 1'b1, 1'b0);
        step();
        check_out("rs_dec", 8'h05, 1'b1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_out("rs_stop", 8'h05, 1'b0, 1'b0);

`ifdef TIMER_PAUSE_EN
        // Pause 3 cycles at count = 2 delays the tick by 3 cycles.
        load_val = 8'h04; start = 1'b1;
        step();
        start = 1'b0;
        check_out("pz0", 8'h04, 1'b1, 1'b0);
        step();
        step();
        check_out("pz2", 8'h02, 1'b1, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("pz_hold%0d", i), 8'h02, 1'b1, 1'b0);
        end
        pause = 1'b0;
        step();
        check_out("pz_1", 8'h01, 1'b1, 1'b0);
        step();
        check_out("pz_tick", 8'h00, 1'b1, 1'b1);
        step();
        check_out("pz_end", 8'h00, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
